// File: rtl/clock_period_meter.sv
// -----------------------------------------------------------------------------
// clock_period_meter
//
// Measures the period and high time of a slow asynchronous square wave in
// clk cycles. Single-shot: every accepted start yields exactly one meas_valid
// pulse or one timeout pulse. Companion to the selectable-speed clock divider
// and used by self-test to confirm its speed setting and duty cycle.
//
// Build option:
//   HIGH_TIME_EN  defined   -> high-time counter present, high_time updated
//                              together with period on each meas_valid
//                 undefined -> high-time logic omitted, high_time tied to 0
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-high reset
//   sig_in      in   asynchronous signal under measurement
//   start       in   one-cycle request, accepted only while busy=0
//   busy        out  measurement in progress
//   meas_valid  out  one-cycle pulse, period/high_time just updated
//   timeout     out  one-cycle pulse, no complete period within TIMEOUT cycles
//   period      out  clk cycles between two successive rising edges
//   high_time   out  clk cycles from the first rising edge to the next fall
//
// FSM states:
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for start, busy=0
//   ARM     | waiting for the first full rising edge of sig_in
//   MEASURE | counting until the next rising edge closes the period
// -----------------------------------------------------------------------------
module clock_period_meter #(
  parameter int          CNT_W       = 28,
  parameter int unsigned TIMEOUT     = 100000000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             meas_valid,
  output logic             timeout,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARM     = 2'd1;
  localparam logic [1:0] MEASURE = 2'd2;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]             state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sig_s;
  logic                   sig_d;
  logic                   rise;
  logic [CNT_W-1:0]       tmo_cnt;
  logic [CNT_W-1:0]       per_cnt;
  logic                   tmo_last;
  logic                   arm_rise;
  logic                   complete;

  // Synchronizer plus one history flop; both edges see the same latency,
  // so the measured intervals are not skewed.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      sig_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      sig_d  <= sig_s;
    end
  end

  assign sig_s    = sync_q[SYNC_STAGES-1];
  assign rise     = sig_s & ~sig_d;
  assign tmo_last = (tmo_cnt == TMO_LAST);

  // A rise on the last allowed ARM cycle cannot complete a period, so the
  // timeout takes it. In MEASURE a completing rise beats the timeout.
  assign arm_rise = (state == ARM) && rise && !tmo_last;
  assign complete = (state == MEASURE) && rise;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      period     <= '0;
      tmo_cnt    <= '0;
      per_cnt    <= '0;
    end else begin
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      case (state)
        IDLE: begin
          // A start coinciding with a result pulse is dropped so that
          // software sees one clean result per request.
          if (start && !meas_valid && !timeout) begin
            state   <= ARM;
            tmo_cnt <= '0;
          end
        end
        ARM: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (tmo_last) begin
            state   <= IDLE;
            timeout <= 1'b1;
          end else if (arm_rise) begin
            state   <= MEASURE;
            per_cnt <= CNT_W'(1);
          end
        end
        MEASURE: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          per_cnt <= per_cnt + 1'b1;
          if (complete) begin
            state      <= IDLE;
            period     <= per_cnt;
            meas_valid <= 1'b1;
          end else if (tmo_last) begin
            state   <= IDLE;
            timeout <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HIGH_TIME_EN
  logic             fall;
  logic [CNT_W-1:0] hi_cnt;
  logic [CNT_W-1:0] hi_meas;
  logic             hi_done;

  assign fall = ~sig_s & sig_d;

  // The fall value is staged in hi_meas and only committed with the period,
  // so a measurement that times out leaves high_time untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_cnt    <= '0;
      hi_meas   <= '0;
      hi_done   <= 1'b0;
      high_time <= '0;
    end else begin
      if (arm_rise) begin
        hi_cnt  <= CNT_W'(1);
        hi_done <= 1'b0;
      end else if ((state == MEASURE) && !hi_done) begin
        hi_cnt <= hi_cnt + 1'b1;
        if (fall) begin
          hi_meas <= hi_cnt;
          hi_done <= 1'b1;
        end
      end
      if (complete) begin
        high_time <= hi_meas;
      end
    end
  end
`else
  assign high_time = '0;
`endif

endmodule

// File: tb/tb_clock_period_meter.sv
module tb_clock_period_meter;

  localparam int          CNT_W = 28;
  localparam int unsigned TMO   = 50;

  logic             clk = 1'b0;
  logic             reset;
  logic             sig_in;
  logic             start;
  logic             busy;
  logic             meas_valid;
  logic             timeout;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;

  clock_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TMO), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .sig_in     (sig_in),
    .start      (start),
    .busy       (busy),
    .meas_valid (meas_valid),
    .timeout    (timeout),
    .period     (period),
    .high_time  (high_time)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit               is_tmo;
    logic [CNT_W-1:0] per;
    logic [CNT_W-1:0] hi;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [CNT_W-1:0] last_per = '0;
  logic [CNT_W-1:0] last_hi  = '0;

  // square-wave generator state, advanced once per clk from step()
  bit gen_on = 0;
  int gen_hi = 4;
  int gen_lo = 4;
  int gen_ph = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [CNT_W-1:0] hi_exp(input int h);
`ifdef HIGH_TIME_EN
    return CNT_W'(h);
`else
    return '0;
`endif
  endfunction

  task automatic push_ok(input int per, input int hi);
    exp_t e;
    e.is_tmo = 1'b0;
    e.per    = CNT_W'(per);
    e.hi     = hi_exp(hi);
    sb.push_back(e);
    last_per = e.per;
    last_hi  = e.hi;
  endtask

  task automatic push_tmo();
    exp_t e;
    e.is_tmo = 1'b1;
    e.per    = last_per;
    e.hi     = last_hi;
    sb.push_back(e);
  endtask

  // Inputs change on the falling edge, well away from the sampling edge.
  task automatic step(input logic st = 1'b0);
    @(negedge clk);
    start = st;
    if (gen_on) begin
      sig_in = (gen_ph < gen_hi);
      gen_ph = (gen_ph + 1) % (gen_hi + gen_lo);
    end
  endtask

  task automatic wait_result(input string tag, input int max_cyc);
    bit seen;
    seen = 0;
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (meas_valid || timeout) begin
        seen = 1;
        break;
      end
    end
    chk(tag, seen, 1);
  endtask

  // scoreboard: every result pulse pops one expectation
  always @(negedge clk) begin
    if (meas_valid || timeout) begin
      chk("valid_timeout_exclusive", meas_valid & timeout, 0);
      n_assert++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_result observed=%0d expected=%0d", 1, 0);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("result_kind_timeout", timeout, e.is_tmo);
        chk("result_period", period, e.per);
        chk("result_high_time", high_time, e.hi);
        chk("busy_low_at_result", busy, 0);
      end
    end
  end

  initial begin
    if (TMO > (2**CNT_W) - 1) begin
      $display("FAIL param_rule TIMEOUT=%0d exceeds counter range", TMO);
      $fatal(1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t_first;
    int v_first;

    reset  = 1'b1;
    start  = 1'b0;
    sig_in = 1'b0;
    repeat (3) step();
    chk("reset_busy", busy, 0);
    chk("reset_meas_valid", meas_valid, 0);
    chk("reset_timeout", timeout, 0);
    chk("reset_period", period, 0);
    chk("reset_high_time", high_time, 0);
    reset = 1'b0;

    // 4 high / 4 low, with extra start pulses while busy that must be ignored
    gen_hi = 4; gen_lo = 4; gen_ph = 0; gen_on = 1;
    repeat (5) step();
    push_ok(8, 4);
    step(1'b1);
    step();
    chk("busy_after_start", busy, 1);
    step(1'b1);
    step();
    step(1'b1);
    wait_result("t1_result_seen", 40);
    repeat (20) step();
    chk("t1_idle_after", busy, 0);
    chk("t1_period_held", period, 8);

    // 3 high / 7 low, start mid-low phase
    gen_hi = 3; gen_lo = 7; gen_ph = 0;
    repeat (25) step();
    push_ok(10, 3);
    step(1'b1);
    wait_result("t2_result_seen", 60);
    // start in the same cycle as meas_valid is dropped
    start = 1'b1;
    step();
    chk("t2_start_on_valid_ignored", busy, 0);
    step();
    chk("t2_still_idle", busy, 0);
    push_ok(10, 3);
    step(1'b1);
    wait_result("t2b_result_seen", 60);

    // sig_in held low: timeout exactly 51 cycles after start
    gen_on = 0;
    sig_in = 1'b0;
    repeat (5) step();
    push_tmo();
    step(1'b1);
    t_first = 0;
    v_first = 0;
    for (int k = 1; k <= 70; k++) begin
      step();
      if (k == 50) chk("t3_busy_before_timeout", busy, 1);
      if (timeout && t_first == 0) t_first = k;
      if (meas_valid && v_first == 0) v_first = k;
    end
    chk("t3_timeout_cycle", t_first, 51);
    chk("t3_no_meas_valid", v_first, 0);
    chk("t3_period_kept", period, 10);

    // completing rise lands on the tmo_cnt = TIMEOUT-1 cycle: rise wins
    push_ok(40, 20);
    step(1'b1);
    t_first = 0;
    v_first = 0;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (k == 8)  sig_in = 1'b1;
      if (k == 28) sig_in = 1'b0;
      if (k == 48) sig_in = 1'b1;
      if (k == 52) sig_in = 1'b0;
      if (timeout && t_first == 0) t_first = k;
      if (meas_valid && v_first == 0) v_first = k;
    end
    chk("t4_valid_cycle", v_first, 51);
    chk("t4_no_timeout", t_first, 0);

    // completing rise one cycle late: timeout, outputs keep 40/20
    push_tmo();
    step(1'b1);
    t_first = 0;
    v_first = 0;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (k == 8)  sig_in = 1'b1;
      if (k == 28) sig_in = 1'b0;
      if (k == 49) sig_in = 1'b1;
      if (k == 53) sig_in = 1'b0;
      if (timeout && t_first == 0) t_first = k;
      if (meas_valid && v_first == 0) v_first = k;
    end
    chk("t4b_timeout_cycle", t_first, 51);
    chk("t4b_no_valid", v_first, 0);

    // reset during MEASURE
    step(1'b1);
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 3) sig_in = 1'b1;
    end
    chk("t5_busy_in_measure", busy, 1);
    reset = 1'b1;
    step();
    chk("t5_reset_busy", busy, 0);
    chk("t5_reset_meas_valid", meas_valid, 0);
    chk("t5_reset_timeout", timeout, 0);
    chk("t5_reset_period", period, 0);
    chk("t5_reset_high_time", high_time, 0);
    reset    = 1'b0;
    last_per = '0;
    last_hi  = '0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 4)  sig_in = 1'b0;
      if (k == 10) sig_in = 1'b1;
      if (k == 14) sig_in = 1'b0;
    end
    chk("t5_idle_after_reset", busy, 0);

    // FSM back in IDLE: a fresh request measures normally
    gen_hi = 4; gen_lo = 4; gen_ph = 0; gen_on = 1;
    repeat (5) step();
    push_ok(8, 4);
    step(1'b1);
    wait_result("t6_result_seen", 40);
    repeat (5) step();
    chk("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
